// File: rtl/rpn_controller_pkg.sv
// Shared types and sizing for the RPN calculator controller.
// CALC_MUL_EN enables the MUL operation (otherwise MUL is rejected as an error).
package rpn_controller_pkg;
  localparam int WORD_WIDTH  = 16;
  localparam int STACK_SIZE  = 8;
  localparam int DEPTH_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0, OP_ADD, OP_SUB, OP_MUL, OP_DUP, OP_DROP, OP_SWAP, OP_CLEAR
  } op_e;

  typedef enum logic [2:0] {
    IDLE, CHECK, POP_A, POP_B, PUSH_1, PUSH_2, CLEAR_LOOP
  } state_e;

  typedef struct packed {
    logic                  ready;
    logic                  done;
    logic                  error;
    logic                  push;
    logic                  pop;
    logic [WORD_WIDTH-1:0] write_data;
  } ctl_out_t;

  // Depth precondition for an op; false means reject with error.
  function automatic logic op_ok(input op_e op, input logic [DEPTH_WIDTH-1:0] depth);
    logic not_full;
    not_full = depth < DEPTH_WIDTH'(STACK_SIZE);
    case (op)
      OP_PUSH:                  return not_full;
      OP_DUP:                   return (depth >= 1) && not_full;
      OP_DROP:                  return depth >= 1;
      OP_ADD, OP_SUB, OP_SWAP:  return depth >= 2;
`ifdef CALC_MUL_EN
      OP_MUL:                   return depth >= 2;
`else
      OP_MUL:                   return 1'b0;
`endif
      default:                  return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic for binary ops: result = b op a (b = second, a = top).
// MUL is only built when CALC_MUL_EN is defined.
module calc_alu
  import rpn_controller_pkg::*;
(
  input  op_e                   op,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
`ifdef CALC_MUL_EN
      OP_MUL:  result = b * a;
`endif
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/rpn_controller.sv
// RPN sequencer: splits key ops into pop/compute/push strobes for an external stack.
// Optional MUL support via CALC_MUL_EN.
module rpn_controller
  import rpn_controller_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [2:0]             key_op,
  input  logic [WORD_WIDTH-1:0]  key_value,
  output logic                   ready,
  output logic                   done,
  output logic                   error,
  output logic                   push,
  output logic                   pop,
  output logic [WORD_WIDTH-1:0]  write_data,
  input  logic [WORD_WIDTH-1:0]  read_data,
  output logic [DEPTH_WIDTH-1:0] depth
);
  state_e                 state_q, state_d;
  op_e                    op_q, op_d, key_op_e;
  logic [WORD_WIDTH-1:0]  a_q, a_d, b_q, b_d, alu_y;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  ctl_out_t               out_q, out_d;

  assign key_op_e = op_e'(key_op);
  assign depth_d  = depth_q + DEPTH_WIDTH'(out_q.push) - DEPTH_WIDTH'(out_q.pop);

  calc_alu u_alu (.op(op_q), .a(a_q), .b(read_data), .result(alu_y));

  // Outputs are registered, so each state decides the strobes of the *next* cycle.
  // The POP_A work happens in CHECK: its pop was already issued on acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = '0;
    case (state_q)
      IDLE: if (key_valid) begin
        op_d    = key_op_e;
        state_d = CHECK;
        if (!op_ok(key_op_e, depth_q)) begin
          out_d.done  = 1'b1;
          out_d.error = 1'b1;
        end else begin
          case (key_op_e)
            OP_PUSH:  begin out_d.push = 1'b1; out_d.write_data = key_value; out_d.done = 1'b1; end
            OP_DUP:   begin out_d.push = 1'b1; out_d.write_data = read_data; out_d.done = 1'b1; end
            OP_DROP:  begin out_d.pop = 1'b1; out_d.done = 1'b1; end
            OP_CLEAR: begin out_d.pop = (depth_q != '0); out_d.done = (depth_q <= 1); end
            default:  out_d.pop = 1'b1;
          endcase
        end
      end
      CHECK: begin
        if (out_q.done) state_d = IDLE;
        else if (op_q == OP_CLEAR) begin
          state_d    = CLEAR_LOOP;
          out_d.pop  = 1'b1;
          out_d.done = (depth_d == 1);
        end else begin
          a_d       = read_data;
          out_d.pop = 1'b1;
          state_d   = POP_B;
        end
      end
      POP_B: begin
        b_d        = read_data;
        out_d.push = 1'b1;
        state_d    = PUSH_1;
        if (op_q == OP_SWAP) out_d.write_data = a_q;
        else begin
          out_d.write_data = alu_y;
          out_d.done       = 1'b1;
        end
      end
      PUSH_1: begin
        if (out_q.done) state_d = IDLE;
        else begin
          out_d.push       = 1'b1;
          out_d.write_data = b_q;
          out_d.done       = 1'b1;
          state_d          = PUSH_2;
        end
      end
      CLEAR_LOOP: begin
        if (out_q.done) state_d = IDLE;
        else begin
          out_d.pop  = 1'b1;
          out_d.done = (depth_d == 1);
        end
      end
      default: state_d = IDLE;
    endcase
    out_d.ready = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      a_q         <= '0;
      b_q         <= '0;
      depth_q     <= '0;
      out_q       <= '0;
      out_q.ready <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      depth_q <= depth_d;
      out_q   <= out_d;
    end
  end

  assign ready      = out_q.ready;
  assign done       = out_q.done;
  assign error      = out_q.error;
  assign push       = out_q.push;
  assign pop        = out_q.pop;
  assign write_data = out_q.write_data;
  assign depth      = depth_q;
endmodule

// File: tb/tb_rpn_controller.sv
// Directed bench: rpn_controller driving a behavioural 8-entry shift-register stack.
module tb_rpn_controller;
  import rpn_controller_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [2:0]  key_op;
  logic [15:0] key_value;
  logic        ready, done, error, push, pop;
  logic [15:0] write_data, read_data;
  logic [3:0]  depth;
  logic [15:0] stk [8];
  int          checks = 0, failures = 0, bad_strobe = 0;

  always #5 clock = ~clock;

  rpn_controller dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_op(key_op),
    .key_value(key_value), .ready(ready), .done(done), .error(error),
    .push(push), .pop(pop), .write_data(write_data), .read_data(read_data),
    .depth(depth)
  );

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) stk[i] <= '0;
    end else if (push) begin
      for (int i = 7; i > 0; i--) stk[i] <= stk[i-1];
      stk[0] <= write_data;
    end else if (pop) begin
      for (int i = 0; i < 7; i++) stk[i] <= stk[i+1];
      stk[7] <= '0;
    end
  end
  assign read_data = stk[0];

  always @(negedge clock)
    if (!reset && ((error && !done) || (push && pop))) bad_strobe++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op; lat = cycles from acceptance edge to done.
  task automatic run_op(input logic [2:0] op, input logic [15:0] val, input bit hold,
                        output int lat, output bit err, output int np, output int npp);
    int w;
    bit seen;
    lat = 0; err = 0; np = 0; npp = 0; seen = 0; w = 0;
    while (!ready && w < 50) begin @(negedge clock); w++; end
    key_op = op; key_value = val; key_valid = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clock);
      if (!hold) key_valid = 1'b0;
      np  += int'(push);
      npp += int'(pop);
      if (done) begin seen = 1; lat = k; err = error; end
    end
    key_valid = 1'b0;
    chk("done_seen", {31'd0, seen}, 1);
    @(negedge clock);
  endtask

  int lat, np, npp;
  bit err;

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_op = '0; key_value = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_strobes", {done, error, push, pop}, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_depth", depth, 0);

    run_op(OP_PUSH, 16'd5, 0, lat, err, np, npp);
    chk("push5_lat", lat, 1);
    chk("push5_err", err, 0);
    run_op(OP_PUSH, 16'd3, 0, lat, err, np, npp);
    run_op(OP_SUB, 16'd0, 0, lat, err, np, npp);
    chk("sub_lat", lat, 3);
    chk("sub_err", err, 0);
    chk("sub_strobes", {np[7:0], npp[7:0]}, {8'd1, 8'd2});
    chk("sub_top", read_data, 16'd2);
    chk("sub_depth", depth, 1);

    run_op(OP_ADD, 16'd0, 0, lat, err, np, npp);
    chk("uflow_lat", lat, 1);
    chk("uflow_err", err, 1);
    chk("uflow_strobes", {np[7:0], npp[7:0]}, 0);
    chk("uflow_depth", depth, 1);
    chk("uflow_top", read_data, 16'd2);

    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);
    chk("clr1_lat", lat, 1);
    chk("clr1_depth", depth, 0);

    for (int i = 1; i <= 8; i++) run_op(OP_PUSH, 16'(i), 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd9, 0, lat, err, np, npp);
    chk("oflow_err", err, 1);
    chk("oflow_lat", lat, 1);
    chk("oflow_top", read_data, 16'd8);
    chk("oflow_depth", depth, 8);
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);
    chk("clr8_lat", lat, 8);
    chk("clr8_pops", npp, 8);
    chk("clr8_depth", depth, 0);
    chk("clr8_top", read_data, 0);
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);
    chk("clr0_lat_err_pops", {lat[7:0], 7'd0, err, npp[7:0]}, {8'd1, 8'd0, 8'd0});

    run_op(OP_PUSH, 16'hFFFF, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'h0001, 0, lat, err, np, npp);
    run_op(OP_ADD, 16'd0, 0, lat, err, np, npp);
    chk("addwrap_top", read_data, 16'h0000);
    chk("addwrap_depth", depth, 1);
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);

    run_op(OP_PUSH, 16'd3, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd5, 0, lat, err, np, npp);
    run_op(OP_SUB, 16'd0, 0, lat, err, np, npp);
    chk("subwrap_top", read_data, 16'hFFFE);
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);

    run_op(OP_PUSH, 16'h0100, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'h0100, 0, lat, err, np, npp);
    run_op(OP_MUL, 16'd0, 0, lat, err, np, npp);
`ifdef CALC_MUL_EN
    chk("mul_err", err, 0);
    chk("mul_lat", lat, 3);
    chk("mul_top", read_data, 16'h0000);
    chk("mul_depth", depth, 1);
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd3, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd7, 0, lat, err, np, npp);
    run_op(OP_MUL, 16'd0, 0, lat, err, np, npp);
    chk("mul21_top", read_data, 16'd21);
`else
    chk("mul_err", err, 1);
    chk("mul_lat", lat, 1);
    chk("mul_top", read_data, 16'h0100);
    chk("mul_depth", depth, 2);
`endif
    run_op(OP_CLEAR, 16'd0, 0, lat, err, np, npp);

    run_op(OP_PUSH, 16'd1, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd2, 0, lat, err, np, npp);
    run_op(OP_SWAP, 16'd0, 1, lat, err, np, npp);
    chk("swap_lat", lat, 4);
    chk("swap_strobes", {np[7:0], npp[7:0]}, {8'd2, 8'd2});
    chk("swap_top", read_data, 16'd1);
    chk("swap_depth", depth, 2);
    run_op(OP_DROP, 16'd0, 0, lat, err, np, npp);
    chk("drop_top", read_data, 16'd2);
    chk("drop_depth", depth, 1);
    run_op(OP_DUP, 16'd0, 0, lat, err, np, npp);
    chk("dup_top_depth", {read_data, 12'd0, depth}, {16'd2, 16'd2});
    run_op(OP_DROP, 16'd0, 0, lat, err, np, npp);
    run_op(OP_DROP, 16'd0, 0, lat, err, np, npp);
    run_op(OP_DROP, 16'd0, 0, lat, err, np, npp);
    chk("drop_empty_err", err, 1);
    chk("drop_empty_depth", depth, 0);

    run_op(OP_PUSH, 16'd4, 0, lat, err, np, npp);
    run_op(OP_PUSH, 16'd6, 0, lat, err, np, npp);
    key_op = OP_ADD; key_valid = 1'b1;
    @(posedge clock);
    @(negedge clock); key_valid = 1'b0;
    @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_depth", depth, 0);
    chk("midrst_strobes", {push, pop}, 0);
    chk("midrst_top", read_data, 0);

    chk("strobe_rules", bad_strobe, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
